// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM encoding and the default counter width.
// The LED PWM generator uses the same width, so capture and generation cover the same range.
package pwm_pkg;

  localparam int PWM_CNT_W       = 26;
  localparam int PWM_SYNC_STAGES = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } pwm_state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes an async input and flags its rising/falling edges.
// Latency: P_SYNC_STAGES cycles to o_sync, with rise/fall combinational from it; no backpressure.
module pwm_edge_sync
  import pwm_pkg::*;
#(
  parameter int P_SYNC_STAGES = PWM_SYNC_STAGES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [P_SYNC_STAGES-1:0] r_sync;
  logic                     r_dly;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[P_SYNC_STAGES-2:0], i_async};
      r_dly  <= r_sync[P_SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[P_SYNC_STAGES-1];
  assign o_rise = o_sync & ~r_dly;
  assign o_fall = ~o_sync & r_dly;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rising-to-rising period of an async PWM input, in clocks.
// Latency: input edge to o_valid is P_SYNC_STAGES+1 clocks; no backpressure, strobe is fire-and-forget.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int P_CNT_W       = PWM_CNT_W,
  parameter int P_SYNC_STAGES = PWM_SYNC_STAGES
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_pwm,
  output logic               o_level,
  output logic [P_CNT_W-1:0] o_high_cnt,
  output logic [P_CNT_W-1:0] o_period_cnt,
  output logic               o_valid,
  output logic               o_timeout
);

  localparam logic [P_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [P_CNT_W-1:0] CNT_ONE = P_CNT_W'(1);

  logic               w_sync;
  logic               w_rise;
  logic               w_fall;
  pwm_state_t         r_state;
  logic [P_CNT_W-1:0] r_cnt;
  logic [P_CNT_W-1:0] r_high;

  pwm_edge_sync #(
    .P_SYNC_STAGES (P_SYNC_STAGES)
  ) u_edge_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_pwm),
    .o_sync  (w_sync),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign o_level = w_sync;

  // r_cnt is 1 on the cycle after a rise, so a sample taken at rise+N reads N.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_high       <= '0;
      o_high_cnt   <= '0;
      o_period_cnt <= '0;
      o_valid      <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      o_valid <= 1'b0;

      if (w_rise) begin
        r_cnt <= CNT_ONE;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_ONE;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state   <= ST_MEAS;
            o_timeout <= 1'b0;
          end
        end
        ST_MEAS: begin
          if (w_fall) begin
            r_high <= r_cnt;
          end
          if (w_rise) begin
            o_period_cnt <= r_cnt;
            o_high_cnt   <= r_high;
            o_valid      <= 1'b1;
          end else if (r_cnt == CNT_MAX) begin
            o_timeout <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a 26-bit instance for the main checks, an 8-bit one for timeout.
module tb_pwm_capture;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_pwm;

  logic        a_lvl, a_vld, a_to;
  logic [25:0] a_high, a_per;
  logic        b_lvl, b_vld, b_to;
  logic [7:0]  b_high, b_per;

  pwm_capture #(.P_CNT_W(26), .P_SYNC_STAGES(2)) u_dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_pwm        (i_pwm),
    .o_level      (a_lvl),
    .o_high_cnt   (a_high),
    .o_period_cnt (a_per),
    .o_valid      (a_vld),
    .o_timeout    (a_to)
  );

  pwm_capture #(.P_CNT_W(8), .P_SYNC_STAGES(2)) u_dut8 (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_pwm        (i_pwm),
    .o_level      (b_lvl),
    .o_high_cnt   (b_high),
    .o_period_cnt (b_per),
    .o_valid      (b_vld),
    .o_timeout    (b_to)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  int a_cyc[$], a_hq[$], a_pq[$];
  int b_cyc[$], b_hq[$], b_pq[$];
  int rise_q[$];
  int b_to_set = -1;
  int b_to_clr = -1;
  logic b_to_prev = 1'b0;

  // Strobe log, sampled 1 time unit after each active edge.
  always @(posedge i_clk) begin
    #1;
    if (a_vld) begin
      a_cyc.push_back(cyc);
      a_hq.push_back(int'(a_high));
      a_pq.push_back(int'(a_per));
    end
    if (b_vld) begin
      b_cyc.push_back(cyc);
      b_hq.push_back(int'(b_high));
      b_pq.push_back(int'(b_per));
    end
    if (b_to && !b_to_prev) b_to_set = cyc;
    if (!b_to && b_to_prev) b_to_clr = cyc;
    b_to_prev = b_to;
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic clear_logs();
    a_cyc.delete(); a_hq.delete(); a_pq.delete();
    b_cyc.delete(); b_hq.delete(); b_pq.delete();
    rise_q.delete();
    b_to_set = -1;
    b_to_clr = -1;
  endtask

  task automatic do_reset();
    #2 i_rst_n = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic drive_pwm(input int h, input int p, input int n);
    for (int i = 0; i < n; i++) begin
      i_pwm = 1'b1;
      rise_q.push_back(cyc);
      repeat (h) @(negedge i_clk);
      i_pwm = 1'b0;
      repeat (p - h) @(negedge i_clk);
    end
  endtask

  task automatic check_strobes(input string tag, input int h, input int p, input int n, input int gap);
    chk({tag, "_count"}, a_cyc.size(), n);
    for (int i = 0; i < a_cyc.size(); i++) begin
      chk($sformatf("%s_high%0d", tag, i), a_hq[i], h);
      chk($sformatf("%s_per%0d", tag, i), a_pq[i], p);
      if (i > 0) chk($sformatf("%s_gap%0d", tag, i), a_cyc[i] - a_cyc[i-1], gap);
    end
    if (a_cyc.size() > 0 && rise_q.size() > 1)
      chk({tag, "_latency"}, a_cyc[0] - rise_q[1], 3);
  endtask

  int exp_h6[4] = '{25, 25, 75, 75};

  initial begin
    i_rst_n = 1'b0;
    i_pwm   = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_level",  int'(a_lvl),  0);
    chk("rst_high",   int'(a_high), 0);
    chk("rst_period", int'(a_per),  0);
    chk("rst_valid",  int'(a_vld),  0);
    chk("rst_timeout", int'(a_to),  0);

    // Held low after reset: nothing happens.
    i_rst_n = 1'b1;
    clear_logs();
    repeat (50) @(negedge i_clk);
    chk("low_strobes", a_cyc.size(), 0);
    chk("low_high",    int'(a_high), 0);
    chk("low_period",  int'(a_per),  0);
    chk("low_timeout", int'(a_to),   0);
    chk("low_level",   int'(a_lvl),  0);

    // Steady 100/25.
    do_reset();
    drive_pwm(25, 100, 5);
    repeat (10) @(negedge i_clk);
    check_strobes("steady", 25, 100, 4, 100);

    // Timeout on the 8-bit instance, then recovery at 10/5.
    do_reset();
    i_pwm = 1'b1;
    rise_q.push_back(cyc);
    repeat (300) @(negedge i_clk);
    chk("to_set",      int'(b_to), 1);
    chk("to_strobes",  b_cyc.size(), 0);
    chk("to_set_time", b_to_set - rise_q[0], 258);
    chk("high_level",  int'(a_lvl), 1);
    i_pwm = 1'b0;
    repeat (5) @(negedge i_clk);
    chk("to_held", int'(b_to), 1);
    clear_logs();
    drive_pwm(5, 10, 3);
    repeat (10) @(negedge i_clk);
    chk("to_clear",      int'(b_to), 0);
    chk("to_clear_time", b_to_clr - rise_q[0], 3);
    chk("rec_count",     b_cyc.size(), 2);
    if (b_cyc.size() > 0) begin
      chk("rec_high",    b_hq[0], 5);
      chk("rec_period",  b_pq[0], 10);
      chk("rec_latency", b_cyc[0] - rise_q[1], 3);
    end

    // Minimum input: toggle every cycle.
    do_reset();
    drive_pwm(1, 2, 10);
    repeat (6) @(negedge i_clk);
    check_strobes("min", 1, 2, 9, 2);

    // Reset in the middle of a period.
    do_reset();
    drive_pwm(25, 100, 3);
    i_pwm = 1'b1;
    repeat (25) @(negedge i_clk);
    i_pwm = 1'b0;
    repeat (15) @(negedge i_clk);
    chk("pre_rst_count",  a_cyc.size(), 3);
    chk("pre_rst_high",   int'(a_high), 25);
    chk("pre_rst_period", int'(a_per), 100);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_high",   int'(a_high), 0);
    chk("mid_rst_period", int'(a_per), 0);
    chk("mid_rst_valid",  int'(a_vld), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    clear_logs();
    repeat (30) @(negedge i_clk);
    drive_pwm(25, 100, 3);
    repeat (10) @(negedge i_clk);
    check_strobes("post_rst", 25, 100, 2, 100);

    // Duty change at a rising edge.
    do_reset();
    drive_pwm(25, 100, 2);
    drive_pwm(75, 100, 2);
    i_pwm = 1'b1;
    rise_q.push_back(cyc);
    repeat (3) @(negedge i_clk);
    i_pwm = 1'b0;
    repeat (10) @(negedge i_clk);
    chk("duty_count", a_cyc.size(), 4);
    for (int i = 0; i < a_cyc.size() && i < 4; i++) begin
      chk($sformatf("duty_high%0d", i), a_hq[i], exp_h6[i]);
      chk($sformatf("duty_per%0d", i),  a_pq[i], 100);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
